// File: rtl/c1541_gcr_codec.sv
// GCR read/write shifter between the track buffer and the VIA: SYNC detection,
// byte assembly and byte-ready strobe on read, serialisation and write enable on write.
module c1541_gcr_codec #(
  parameter int unsigned SYNC_LEN   = 10,
  parameter int unsigned BYTE_PULSE = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       bit_strobe,
  input  logic       bit_in,
  input  logic       mtr,
  input  logic       mode,
  input  logic       soe,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       sync_n,
  output logic       byte_n,
  output logic       wr_bit,
  output logic       wr_en
);

  localparam logic [3:0] SyncLen  = 4'(SYNC_LEN);
  localparam logic [3:0] PulseLen = 4'(BYTE_PULSE);

  logic       mode_q, mode_d;
  logic [3:0] ones_cnt_q, ones_cnt_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] rd_shift_q, rd_shift_d;
  logic [7:0] wr_shift_q, wr_shift_d;
  logic [3:0] pulse_cnt_q, pulse_cnt_d;
  logic [7:0] dout_q, dout_d;
  logic       sync_n_q, sync_n_d;
  logic       wr_bit_q, wr_bit_d;
  logic       wr_en_q, wr_en_d;

  logic       mode_chg;
  logic [3:0] ones_cur, ones_inc;
  logic [2:0] bit_cur;
  logic       byte_evt;

  always_comb begin
    mode_d      = mode;
    ones_cnt_d  = ones_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    rd_shift_d  = rd_shift_q;
    wr_shift_d  = wr_shift_q;
    dout_d      = dout_q;
    sync_n_d    = sync_n_q;
    wr_bit_d    = wr_bit_q;
    wr_en_d     = wr_en_q;
    byte_evt    = 1'b0;

    // A mode change restarts the byte framing before any coinciding strobe is handled.
    mode_chg    = (mode != mode_q);
    ones_cur    = mode_chg ? 4'd0 : ones_cnt_q;
    bit_cur     = mode_chg ? 3'd0 : bit_cnt_q;
    ones_inc    = (ones_cur == 4'd15) ? 4'd15 : ones_cur + 4'd1;
    ones_cnt_d  = ones_cur;
    bit_cnt_d   = bit_cur;

    if (!mtr) begin
      sync_n_d = 1'b1;
      wr_en_d  = 1'b0;
      wr_bit_d = 1'b0;
    end else if (mode) begin
      wr_en_d  = 1'b0;
      wr_bit_d = 1'b0;
      if (bit_strobe) begin
        rd_shift_d = {rd_shift_q[6:0], bit_in};
        ones_cnt_d = bit_in ? ones_inc : 4'd0;
        if (bit_in && (ones_inc >= SyncLen)) begin
          sync_n_d  = 1'b0;
          bit_cnt_d = 3'd0;
        end else begin
          if (!bit_in) sync_n_d = 1'b1;
          bit_cnt_d = bit_cur + 3'd1;
          if (bit_cur == 3'd7) begin
            dout_d   = {rd_shift_q[6:0], bit_in};
            byte_evt = soe;
          end
        end
      end
    end else begin
      wr_en_d    = 1'b1;
      sync_n_d   = 1'b1;
      ones_cnt_d = 4'd0;
      if (bit_strobe) begin
        bit_cnt_d = bit_cur + 3'd1;
        if (bit_cur == 3'd0) begin
          wr_shift_d = din;
          wr_bit_d   = din[7];
          byte_evt   = soe;
        end else begin
          wr_bit_d   = wr_shift_q[6];
          wr_shift_d = {wr_shift_q[6:0], 1'b0};
        end
      end
    end

    // A new byte during a running pulse reloads it so byte_n stays low throughout.
    if (byte_evt)                  pulse_cnt_d = PulseLen;
    else if (pulse_cnt_q != 4'd0)  pulse_cnt_d = pulse_cnt_q - 4'd1;
    else                           pulse_cnt_d = 4'd0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q      <= 1'b1;
      ones_cnt_q  <= 4'd0;
      bit_cnt_q   <= 3'd0;
      rd_shift_q  <= 8'd0;
      wr_shift_q  <= 8'd0;
      pulse_cnt_q <= 4'd0;
      dout_q      <= 8'd0;
      sync_n_q    <= 1'b1;
      wr_bit_q    <= 1'b0;
      wr_en_q     <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      ones_cnt_q  <= ones_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      rd_shift_q  <= rd_shift_d;
      wr_shift_q  <= wr_shift_d;
      pulse_cnt_q <= pulse_cnt_d;
      dout_q      <= dout_d;
      sync_n_q    <= sync_n_d;
      wr_bit_q    <= wr_bit_d;
      wr_en_q     <= wr_en_d;
    end
  end

  assign dout   = dout_q;
  assign sync_n = sync_n_q;
  assign byte_n = (pulse_cnt_q == 4'd0);
  assign wr_bit = wr_bit_q;
  assign wr_en  = wr_en_q;

endmodule

// File: tb/tb_c1541_gcr_codec.sv
// Bench for c1541_gcr_codec: two instances (default and SYNC_LEN=5/BYTE_PULSE=15) checked
// every cycle against a bit-history / timestamp model, plus hand-computed spot checks.
module tb_c1541_gcr_codec;

  logic clk = 1'b0;
  logic reset_n;
  logic bit_strobe, bit_in, mtr, mode, soe;
  logic [7:0] din;

  logic [1:0][7:0] dout_w;
  logic [1:0]      sync_n_w, byte_n_w, wr_bit_w, wr_en_w;

  always #5 clk = ~clk;

  c1541_gcr_codec u_dut (
    .clk(clk), .reset_n(reset_n), .bit_strobe(bit_strobe), .bit_in(bit_in), .mtr(mtr),
    .mode(mode), .soe(soe), .din(din), .dout(dout_w[0]), .sync_n(sync_n_w[0]),
    .byte_n(byte_n_w[0]), .wr_bit(wr_bit_w[0]), .wr_en(wr_en_w[0])
  );

  c1541_gcr_codec #(.SYNC_LEN(5), .BYTE_PULSE(15)) u_dut5 (
    .clk(clk), .reset_n(reset_n), .bit_strobe(bit_strobe), .bit_in(bit_in), .mtr(mtr),
    .mode(mode), .soe(soe), .din(din), .dout(dout_w[1]), .sync_n(sync_n_w[1]),
    .byte_n(byte_n_w[1]), .wr_bit(wr_bit_w[1]), .wr_en(wr_en_w[1])
  );

  int n_cmp = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: read byte = last 8 bits received, write bit = din bit by index, pulse by timestamp.
  int L [2] = '{10, 5};
  int P [2] = '{4, 15};
  int ones [2], nbits [2], hist [2], wbyte [2], last_evt [2];
  int e_dout [2], e_sync_n [2], e_wr_bit [2], e_wr_en [2];
  int cyc = 0;
  bit prev_mode;

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      ones[k] = 0; nbits[k] = 0; hist[k] = 0; wbyte[k] = 0; last_evt[k] = -1000;
      e_dout[k] = 0; e_sync_n[k] = 1; e_wr_bit[k] = 0; e_wr_en[k] = 0;
    end
    prev_mode = 1'b1;
  endtask

  task automatic model_step();
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (mode != prev_mode) begin nbits[k] = 0; ones[k] = 0; end
      if (!mtr) begin
        e_sync_n[k] = 1; e_wr_en[k] = 0; e_wr_bit[k] = 0;
      end else if (mode) begin
        e_wr_en[k] = 0; e_wr_bit[k] = 0;
        if (bit_strobe) begin
          hist[k] = ((hist[k] * 2) + int'(bit_in)) % 256;
          ones[k] = bit_in ? ((ones[k] < 15) ? ones[k] + 1 : 15) : 0;
          if (bit_in && ones[k] >= L[k]) begin
            e_sync_n[k] = 0; nbits[k] = 0;
          end else begin
            if (!bit_in) e_sync_n[k] = 1;
            nbits[k]++;
            if (nbits[k] == 8) begin
              nbits[k] = 0; e_dout[k] = hist[k];
              if (soe) last_evt[k] = cyc;
            end
          end
        end
      end else begin
        e_wr_en[k] = 1; e_sync_n[k] = 1; ones[k] = 0;
        if (bit_strobe) begin
          if (nbits[k] == 0) begin
            wbyte[k] = int'(din);
            if (soe) last_evt[k] = cyc;
          end
          e_wr_bit[k] = (wbyte[k] >> (7 - nbits[k])) & 1;
          nbits[k] = (nbits[k] + 1) % 8;
        end
      end
    end
    prev_mode = mode;
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) model_reset();
    else          model_step();
  end

  always @(negedge clk) begin
    if (chk_on) begin
      for (int k = 0; k < 2; k++) begin
        check($sformatf("dout[%0d]", k),   int'(dout_w[k]),   e_dout[k]);
        check($sformatf("sync_n[%0d]", k), int'(sync_n_w[k]), e_sync_n[k]);
        check($sformatf("byte_n[%0d]", k), int'(byte_n_w[k]),
              ((cyc - last_evt[k]) >= P[k]) ? 1 : 0);
        check($sformatf("wr_bit[%0d]", k), int'(wr_bit_w[k]), e_wr_bit[k]);
        check($sformatf("wr_en[%0d]", k),  int'(wr_en_w[k]),  e_wr_en[k]);
      end
    end
  end

  task automatic clks(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Returns 1 clk after the strobe edge so the resulting outputs are visible.
  task automatic send(input logic b);
    bit_strobe = 1'b1; bit_in = b;
    @(posedge clk); #1;
    bit_strobe = 1'b0;
  endtask

  logic [7:0]  byte_v;
  logic [7:0]  wr_exp;
  logic [23:0] pat;
  int          cnt;

  initial begin
    reset_n = 1'b0; bit_strobe = 1'b0; bit_in = 1'b0;
    mtr = 1'b1; mode = 1'b1; soe = 1'b1; din = 8'h00;
    model_reset();
    chk_on = 1'b1;
    clks(3);
    check("rst dout", int'(dout_w[0]), 0);
    check("rst sync_n", int'(sync_n_w[0]), 1);
    check("rst byte_n", int'(byte_n_w[0]), 1);
    check("rst wr_en", int'(wr_en_w[0]), 0);
    reset_n = 1'b1;
    clks(2);

    // 12 ones then 0x52, one strobe per 32 clks
    for (int i = 1; i <= 12; i++) begin
      send(1'b1);
      if (i == 5)  check("sync5 at 5th one", int'(sync_n_w[1]), 0);
      if (i == 8)  check("pre-sync byte", int'(dout_w[0]), 8'hFF);
      if (i == 9)  check("sync_n after 9", int'(sync_n_w[0]), 1);
      if (i == 10) check("sync_n after 10", int'(sync_n_w[0]), 0);
      clks(31);
    end
    byte_v = 8'h52;
    for (int j = 7; j >= 0; j--) begin
      send(byte_v[j]);
      if (j == 7) check("sync release", int'(sync_n_w[0]), 1);
      if (j == 1) check("dout before 8th", int'(dout_w[0]), 8'hFF);
      if (j == 0) begin
        check("dout 0x52", int'(dout_w[0]), 8'h52);
        cnt = 0;
        while (!byte_n_w[0] && cnt < 40) begin cnt++; clks(1); end
        check("byte_n width", cnt, 4);
      end
      if (j != 0) clks(31);
    end
    clks(10);

    // SYNC threshold: 9 ones then 0, then 10 ones then 0
    for (int i = 1; i <= 9; i++) begin
      send(1'b1);
      check("no sync below 10", int'(sync_n_w[0]), 1);
      if (i == 5) check("sync5 threshold", int'(sync_n_w[1]), 0);
      clks(2);
    end
    send(1'b0); clks(2);
    for (int i = 1; i <= 10; i++) begin
      send(1'b1);
      if (i == 10) check("sync at 10 ones", int'(sync_n_w[0]), 0);
      clks(2);
    end
    send(1'b0);
    check("sync off after 0", int'(sync_n_w[0]), 1);
    clks(20);

    // Write 0xA5 then 0x3C
    mode = 1'b0; din = 8'hA5;
    clks(1);
    check("wr_en 1 clk", int'(wr_en_w[0]), 1);
    clks(3);
    wr_exp = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      send(1'b0);
      check($sformatf("wr_bit A5 #%0d", i), int'(wr_bit_w[0]), int'(wr_exp[7 - i]));
      if (i == 0) check("wr byte_n strobe1", int'(byte_n_w[0]), 0);
      if (i == 1) check("wr byte_n done", int'(byte_n_w[0]), 1);
      clks(5);
    end
    din = 8'h3C;
    send(1'b0);
    check("wr_bit 3C #0", int'(wr_bit_w[0]), 0);
    check("wr byte_n strobe9", int'(byte_n_w[0]), 0);
    clks(5);
    send(1'b0); clks(5);
    send(1'b0);
    check("wr_bit 3C #2", int'(wr_bit_w[0]), 1);
    clks(5);

    // Switch to read coincident with a strobe: framing restarts, 0x9B needs 8 strobes
    mode = 1'b1;
    byte_v = 8'h9B;
    for (int j = 7; j >= 0; j--) begin
      send(byte_v[j]);
      if (j == 7) check("wr_en off in read", int'(wr_en_w[0]), 0);
      clks(2);
    end
    check("dout 0x9B", int'(dout_w[0]), 8'h9B);
    clks(20);

    // Back-to-back bytes, one strobe per clk
    pat = 24'h55AA55;
    for (int i = 0; i < 24; i++) begin
      bit_strobe = 1'b1; bit_in = pat[23 - i];
      @(posedge clk); #1;
      if (i >= 7)  check("b2b byte_n held", int'(byte_n_w[1]), 0);
      if (i == 7)  check("b2b dout 55", int'(dout_w[1]), 8'h55);
      if (i == 14) check("b2b dout hold", int'(dout_w[1]), 8'h55);
      if (i == 15) check("b2b dout AA", int'(dout_w[1]), 8'hAA);
    end
    bit_strobe = 1'b0;
    clks(20);

    // Motor off after 3 bits, strobes ignored, then 5 more bits complete 0xC9
    send(1'b1); clks(2); send(1'b1); clks(2); send(1'b0); clks(2);
    mtr = 1'b0;
    clks(1);
    check("idle sync_n", int'(sync_n_w[0]), 1);
    check("idle wr_en", int'(wr_en_w[0]), 0);
    send(1'b1); clks(2); send(1'b1); clks(2);
    mtr = 1'b1;
    byte_v = 8'h49;
    for (int j = 4; j >= 0; j--) begin
      send(byte_v[j]);
      if (j == 1) check("idle hold dout", int'(dout_w[0]), 8'h55);
      if (j == 0) check("resume dout C9", int'(dout_w[0]), 8'hC9);
      clks(2);
    end
    clks(10);
    mode = 1'b0; clks(2);
    check("wr_en write", int'(wr_en_w[0]), 1);
    mtr = 1'b0; clks(1);
    check("wr_en idle", int'(wr_en_w[0]), 0);
    mtr = 1'b1; mode = 1'b1; clks(4);

    // Reset while a pulse and a SYNC are active
    for (int i = 0; i < 10; i++) begin
      bit_strobe = 1'b1; bit_in = 1'b1;
      @(posedge clk); #1;
    end
    bit_strobe = 1'b0;
    check("pre-rst byte_n", int'(byte_n_w[0]), 0);
    check("pre-rst sync_n", int'(sync_n_w[0]), 0);
    #2 reset_n = 1'b0;
    #1;
    check("async byte_n", int'(byte_n_w[0]), 1);
    check("async sync_n", int'(sync_n_w[0]), 1);
    check("async dout", int'(dout_w[0]), 0);
    clks(2);
    reset_n = 1'b1;
    clks(1);
    byte_v = 8'h3C;
    for (int j = 7; j >= 0; j--) begin
      send(byte_v[j]);
      if (j == 1) begin
        check("post-rst 7 bits dout", int'(dout_w[0]), 0);
        check("post-rst 7 bits byte_n", int'(byte_n_w[0]), 1);
      end
      if (j == 0) begin
        check("post-rst dout", int'(dout_w[0]), 8'h3C);
        check("post-rst byte_n", int'(byte_n_w[0]), 0);
      end
      clks(1);
    end
    clks(20);

    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
